// File: rtl/adder_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_accumulator_pkg
// Description : Shared EDSAC digit-timing constants, clear-control state
//               encoding and the full-adder carry helper used by the
//               serial accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_accumulator_pkg;

    // Digit positions per accumulator circulation (LSB first).
    localparam int DEFAULT_ACC_LEN = 72;
    // Digit index of the least significant digit (the d0 slot).
    localparam int DIGIT_LSB       = 0;
    // Digit index of the sign digit for the default circulation length.
    localparam int DIGIT_SIGN      = DEFAULT_ACC_LEN - 1;

    // Clear control: idle, or running a clearing circulation.
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Majority of three: the carry out of a single-digit full adder.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_accumulator_if
// Description : Serial operand/control and status bundle of the accumulator.
//               master : drives adder_b, acc_clr, ovf_clr; observes status.
//               slave  : the accumulator itself.
//               Signals: adder_b  serial operand digit
//                        acc_clr  clear request (one cycle)
//                        ovf_clr  overflow flag clear
//                        acc_out  serial accumulator digit (tank tap)
//                        d0       high while digit counter = 0
//                        acc_sign sign digit of last circulation
//                        overflow sticky two's-complement overflow
//                        clearing high throughout a clearing circulation
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_accumulator_if;

    logic adder_b;
    logic acc_clr;
    logic ovf_clr;
    logic acc_out;
    logic d0;
    logic acc_sign;
    logic overflow;
    logic clearing;

    modport master (
        output adder_b, acc_clr, ovf_clr,
        input  acc_out, d0, acc_sign, overflow, clearing
    );

    modport slave (
        input  adder_b, acc_clr, ovf_clr,
        output acc_out, d0, acc_sign, overflow, clearing
    );

endinterface
`default_nettype wire

// File: rtl/delay_rst.sv
`default_nettype none
// ============================================================================
// Module      : delay_rst
// Description : Resettable serial delay line. o_dout presents the digit that
//               was sampled on i_din exactly INTERVAL clock edges earlier.
//               Ports: clk, rst_n (async active-low), i_din, o_dout.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_rst #(
    parameter int INTERVAL = 72
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_dout
);

    generate
        if (INTERVAL == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_q <= 1'b0;
                else        r_q <= i_din;
            end
            assign o_dout = r_q;
        end else begin : g_multi
            logic [INTERVAL-1:0] r_sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[INTERVAL-2:0], i_din};
            end
            assign o_dout = r_sr[INTERVAL-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/adder_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : adder_accumulator
// Description : Bit-serial two's-complement accumulator. A circulating tank
//               of ACC_LEN digits is added digit-by-digit (LSB first) to the
//               serial operand, with clear-and-add and a sticky overflow flag.
//               Ports: clk   digit-pulse clock
//                      rst_n asynchronous active-low reset
//                      bus   adder_accumulator_if.slave (operand, controls,
//                            acc_out, d0, acc_sign, overflow, clearing)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int ACC_LEN = DEFAULT_ACC_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_accumulator_if.slave  bus
);

    localparam int                 c_cnt_w      = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_digit_lsb  = c_cnt_w'(DIGIT_LSB);
    localparam logic [c_cnt_w-1:0] c_digit_last = c_cnt_w'(ACC_LEN - 1);

    logic [c_cnt_w-1:0] r_digit;
    logic               r_carry;
    logic               r_pending;
    logic               r_sign;
    logic               r_overflow;
    clr_state_t         r_clr_state;
    clr_state_t         w_clr_state_nxt;

    logic w_at_lsb, w_at_sign, w_clear_req, w_clearing;
    logic w_tank_out, w_a, w_cin, w_sum, w_cout;
    logic w_ovf_set, w_ovf_clr;

    assign w_at_lsb    = (r_digit == c_digit_lsb);
    assign w_at_sign   = (r_digit == c_digit_last);
    assign w_clear_req = r_pending | bus.acc_clr;

    // Clear control. The decision is taken in the d0 slot so a clearing
    // circulation always spans digits 0..ACC_LEN-1; a request arriving in
    // that very slot is honoured without waiting a full circulation.
    always_comb begin
        w_clr_state_nxt = r_clr_state;
        w_clearing      = 1'b0;
        if (w_at_lsb) begin
            w_clearing      = w_clear_req;
            w_clr_state_nxt = w_clear_req ? CLR_RUN : CLR_IDLE;
        end else begin
            w_clearing      = (r_clr_state == CLR_RUN);
        end
    end

    // Serial full adder. The carry chain restarts at d0, which also drops the
    // carry out of the sign digit (modulo 2^ACC_LEN arithmetic).
    assign w_a    = w_clearing ? 1'b0 : w_tank_out;
    assign w_cin  = w_at_lsb ? 1'b0 : r_carry;
    assign w_sum  = w_a ^ bus.adder_b ^ w_cin;
    assign w_cout = maj3(w_a, bus.adder_b, w_cin);

    // Overflow: carry into the sign digit differs from carry out of it.
    assign w_ovf_set = w_at_sign & (w_cin ^ w_cout);
    assign w_ovf_clr = bus.ovf_clr | (w_at_lsb & w_clearing);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit     <= '0;
            r_carry     <= 1'b0;
            r_pending   <= 1'b0;
            r_clr_state <= CLR_IDLE;
            r_sign      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_digit     <= w_at_sign ? '0 : r_digit + 1'b1;
            r_carry     <= w_cout;
            // Requests seen outside the d0 slot wait for the next one; this
            // also queues a follow-on clear when requested mid-clear.
            r_pending   <= w_at_lsb ? 1'b0 : w_clear_req;
            r_clr_state <= w_clr_state_nxt;
            if (w_at_sign) begin
                r_sign <= w_sum;
            end
            // A coincident set takes priority over any clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    delay_rst #(
        .INTERVAL (ACC_LEN)
    ) u_tank (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (w_sum),
        .o_dout (w_tank_out)
    );

    assign bus.acc_out  = w_tank_out;
    assign bus.d0       = w_at_lsb;
    assign bus.acc_sign = r_sign;
    assign bus.overflow = r_overflow;
    assign bus.clearing = w_clearing;

endmodule
`default_nettype wire

// File: tb/tb_adder_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_accumulator
// Description : Table-driven self-checking bench for adder_accumulator at
//               the default 72-digit circulation, plus a mid-circulation
//               reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_accumulator;

    localparam int          N    = 72;
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONES = '1;
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] D0   = 72'd1;

    typedef struct {
        logic [N-1:0] b;        // operand word, serialised LSB first
        logic [N-1:0] clr;      // acc_clr asserted at digit k when bit k set
        logic [N-1:0] ovc;      // ovf_clr asserted at digit k when bit k set
        logic [N-1:0] exp_out;  // accumulator word read out this circulation
        int           exp_cnt;  // digits with clearing high
        logic         exp_sign; // acc_sign after the circulation
        logic         exp_ovf;  // overflow after the circulation
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[26];

    adder_accumulator_if bus_if ();

    adder_accumulator #(
        .ACC_LEN (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [N-1:0] b, input logic [N-1:0] clr,
                                input logic [N-1:0] ovc, input logic [N-1:0] exp_out,
                                input int exp_cnt, input logic exp_sign,
                                input logic exp_ovf);
        vec_t v;
        v.b = b; v.clr = clr; v.ovc = ovc; v.exp_out = exp_out;
        v.exp_cnt = exp_cnt; v.exp_sign = exp_sign; v.exp_ovf = exp_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one full circulation; entered and left just after a rising edge
    // with the digit counter at 0.
    task automatic run_circ(input vec_t v, input string tag);
        logic [N-1:0] out_w;
        int           clr_cnt;
        int           d0_err;
        out_w = '0; clr_cnt = 0; d0_err = 0;
        for (int k = 0; k < N; k++) begin
            bus_if.adder_b = v.b[k];
            bus_if.acc_clr = v.clr[k];
            bus_if.ovf_clr = v.ovc[k];
            @(negedge clk);
            out_w[k] = bus_if.acc_out;
            if (bus_if.clearing) clr_cnt++;
            if (bus_if.d0 !== (k == 0)) d0_err++;
            @(posedge clk);
            #1;
        end
        bus_if.adder_b = 1'b0;
        bus_if.acc_clr = 1'b0;
        bus_if.ovf_clr = 1'b0;
        chk({tag, " acc_out word"}, out_w, v.exp_out);
        chk({tag, " clearing digits"}, N'(clr_cnt), N'(v.exp_cnt));
        chk({tag, " d0 misplaced"}, N'(d0_err), ZERO);
        chk({tag, " acc_sign"}, N'(bus_if.acc_sign), N'(v.exp_sign));
        chk({tag, " overflow"}, N'(bus_if.overflow), N'(v.exp_ovf));
    endtask

    initial begin
        vec_t z;
        bus_if.adder_b = 1'b0;
        bus_if.acc_clr = 1'b0;
        bus_if.ovf_clr = 1'b0;

        //          b      clr             ovc          exp_out  cnt sign ovf
        vecs[0]  = mk(72'd5, ZERO,         ZERO,        ZERO,    0,  0,   0);
        vecs[1]  = mk(72'd3, ZERO,         ZERO,        72'd5,   0,  0,   0);
        vecs[2]  = mk(ZERO,  ZERO,         ZERO,        72'd8,   0,  0,   0);
        vecs[3]  = mk(72'd2, D0,           ZERO,        72'd8,   N,  0,   0);
        vecs[4]  = mk(ONES,  ZERO,         ZERO,        72'd2,   0,  0,   0);
        vecs[5]  = mk(ONES,  ZERO,         ZERO,        72'd1,   0,  0,   0);
        vecs[6]  = mk(ZERO,  ZERO,         ZERO,        ZERO,    0,  0,   0);
        vecs[7]  = mk(MAXP,  ZERO,         ZERO,        ZERO,    0,  0,   0);
        vecs[8]  = mk(72'd1, ZERO,         ZERO,        MAXP,    0,  1,   1);
        vecs[9]  = mk(ZERO,  ZERO,         D0 << 5,     MINN,    0,  1,   0);
        vecs[10] = mk(MINN,  ZERO,         ZERO,        MINN,    0,  0,   1);
        vecs[11] = mk(72'd9, ZERO,         ZERO,        ZERO,    0,  0,   1);
        vecs[12] = mk(ZERO,  D0 << 17,     ZERO,        72'd9,   0,  0,   1);
        vecs[13] = mk(72'd4, ZERO,         ZERO,        72'd9,   N,  0,   0);
        vecs[14] = mk(72'd7, D0 | (D0 << 30), ZERO,     72'd4,   N,  0,   0);
        vecs[15] = mk(72'd1, ZERO,         ZERO,        72'd7,   N,  0,   0);
        vecs[16] = mk(ZERO,  ZERO,         ZERO,        72'd1,   0,  0,   0);
        vecs[17] = mk(72'h5A, D0,          ZERO,        72'd1,   N,  0,   0);
        vecs[18] = mk(ZERO,  ZERO,         ZERO,        72'h5A,  0,  0,   0);
        vecs[19] = mk(ZERO,  ZERO,         ZERO,        72'h5A,  0,  0,   0);
        vecs[20] = mk(ZERO,  ZERO,         ZERO,        72'h5A,  0,  0,   0);
        vecs[21] = mk(ZERO,  ZERO,         ZERO,        72'h5A,  0,  0,   0);
        vecs[22] = mk(ZERO,  ZERO,         ZERO,        72'h5A,  0,  0,   0);
        vecs[23] = mk(MAXP,  D0,           ZERO,        72'h5A,  N,  0,   0);
        vecs[24] = mk(72'd1, ZERO,         D0 << (N-1), MAXP,    0,  1,   1);
        vecs[25] = mk(ZERO,  ZERO,         ZERO,        MINN,    0,  1,   1);

        // Reset state, observed while reset is held.
        repeat (2) @(negedge clk);
        chk("reset acc_out",  N'(bus_if.acc_out),  ZERO);
        chk("reset d0",       N'(bus_if.d0),       72'd1);
        chk("reset clearing", N'(bus_if.clearing), ZERO);
        chk("reset acc_sign", N'(bus_if.acc_sign), ZERO);
        chk("reset overflow", N'(bus_if.overflow), ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            run_circ(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-addition at digit 40 with a clear request pending.
        for (int k = 0; k <= 40; k++) begin
            bus_if.adder_b = 1'b1;
            bus_if.acc_clr = (k == 20);
            @(negedge clk);
            if (k < 40) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        #1;
        chk("midreset acc_out",  N'(bus_if.acc_out),  ZERO);
        chk("midreset d0",       N'(bus_if.d0),       72'd1);
        chk("midreset clearing", N'(bus_if.clearing), ZERO);
        chk("midreset acc_sign", N'(bus_if.acc_sign), ZERO);
        chk("midreset overflow", N'(bus_if.overflow), ZERO);
        bus_if.adder_b = 1'b0;
        bus_if.acc_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        z = mk(ZERO, ZERO, ZERO, ZERO, 0, 0, 0);
        run_circ(z, "postreset0");
        run_circ(z, "postreset1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 Parameter ACC_LEN, default 72, digit positions per accumulator circulation (LSB first, digit ACC_LEN-1 is sign).
REQ-002 clk  input  1  digit-pulse clock; one serial digit per rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 adder_b  input  1  serial operand from complementer/collater unit, already aligned: digit k presented while digit counter = k.
REQ-005 acc_clr  input  1  one-cycle request to clear accumulator on next circulation.
REQ-006 ovf_clr  input  1  clears overflow flag.
REQ-007 acc_out  output  1  serial accumulator digit leaving the tank (current tap).
REQ-008 d0  output  1  high while digit counter = 0.
REQ-009 acc_sign  output  1  sign digit of last completed circulation.
REQ-010 overflow  output  1  sticky two's-complement overflow flag.
REQ-011 clearing  output  1  high throughout a clearing circulation.

Function
REQ-012 Digit counter SHALL count 0..ACC_LEN-1, incrementing every clk, wrapping ACC_LEN-1 -> 0.
REQ-013 Tank SHALL be an ACC_LEN-digit circulating store; acc_out = digit written ACC_LEN cycles earlier.
REQ-014 Each cycle: a = clearing ? 0 : acc_out; sum = a ^ adder_b ^ cin; digit written to tank = sum.
REQ-015 cin SHALL be 0 when counter = 0, else the registered carry; carry register SHALL load maj(a, adder_b, cin) every cycle.
REQ-016 Carry out of digit ACC_LEN-1 SHALL be discarded (no end-around carry); arithmetic is modulo 2^ACC_LEN two's complement.
REQ-017 adder_b held 0 SHALL leave accumulator contents unchanged (pure recirculation).
REQ-018 acc_clr SHALL set a pending flag; clearing SHALL assert at the next counter = 0 and deassert after exactly ACC_LEN cycles; a request arriving when counter = 0 starts clearing that same cycle.
REQ-019 During clearing, adder_b SHALL still be added, so the tank ends holding the adder_b word (clear-and-add).
REQ-020 acc_clr asserted while clearing SHALL queue one further clearing circulation immediately following.
REQ-021 At counter = ACC_LEN-1, acc_sign SHALL register sum; overflow SHALL set if cin != carry-out at that digit.
REQ-022 overflow SHALL clear on ovf_clr or on the first cycle of a clearing circulation; a simultaneous set SHALL win over clear.
REQ-023 d0 and acc_out SHALL be combinational from registered state only (no adder_b path to outputs).

Reset
REQ-024 rst_n low SHALL asynchronously zero counter, carry, tank contents, pending flag, clearing, acc_sign, overflow.
REQ-025 After reset release, first rising edge SHALL see counter = 0 (d0 = 1) and acc_out = 0.
REQ-026 Reset mid-circulation SHALL abandon any partial sum or clear; no residue SHALL appear afterwards.

Structure
REQ-027 ACC_LEN default and digit-index constants (DIGIT_LSB, DIGIT_SIGN) SHALL live in the shared EDSAC timing package.
REQ-028 Tank SHALL be one sub-module, delay_rst: resettable serial delay with INTERVAL parameter, instantiated with INTERVAL = ACC_LEN.
REQ-029 Counter, carry logic, clear control and flags SHALL reside in adder_accumulator.

Verification
REQ-030 Reset, then adder_b = 5 then 3 on consecutive circulations -> acc_out stream reads 8 on third circulation, overflow = 0.
REQ-031 Accumulator = 2, adder_b = all-ones word (-1) twice -> accumulator 0, acc_sign 0, overflow 0 (carry at sign discarded).
REQ-032 Accumulator = 2^(ACC_LEN-1)-1, add 1 -> acc_sign 1, overflow 1; ovf_clr pulse -> overflow 0.
REQ-033 acc_clr pulsed at counter = 17 with accumulator = 9, adder_b = 4 during next circulation -> clearing high from next d0 for ACC_LEN cycles, result 4, overflow cleared.
REQ-034 rst_n low at counter = 40 mid-addition -> all outputs 0 immediately; after release d0 on first edge, accumulator reads 0.
REQ-035 adder_b held 0 for 5 circulations with accumulator = 0x5A -> acc_out pattern repeats unchanged every ACC_LEN cycles.
